// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART transmit scheduler family.
// Optional build macro consumed by users of this package: UART_TX_CHANNEL_TAG_EN.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    SETTLE    = 2'd0,
    IDLE      = 2'd1,
    WAIT_DONE = 2'd2,
    DRAIN     = 2'd3
  } sched_state_e;

  typedef enum logic {
    PHASE_TAG  = 1'b0,
    PHASE_DATA = 1'b1
  } tag_phase_e;

  localparam logic [7:0] TAG_BASE_DEFAULT = 8'hA0;

  // Index width for n requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping modulo the requester count.
module rr_arbiter #(
  parameter int numRequesters = 4,
  parameter int idWidth       = 2
) (
  input  logic [numRequesters-1:0] request_i,
  input  logic [idWidth-1:0]       pointer_i,
  output logic                     found_o,
  output logic [idWidth-1:0]       winner_o
);

  // Scan offsets from the far end down so the nearest offset is written last.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    for (int k = numRequesters - 1; k >= 0; k--) begin
      int               cand;
      logic [idWidth-1:0] cand_idx;
      cand = int'(pointer_i) + k;
      if (cand >= numRequesters) cand = cand - numRequesters;
      cand_idx = idWidth'(cand);
      if (request_i[cand_idx]) begin
        found_o  = 1'b1;
        winner_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART byte transmitter among several byte sources.
// Build option UART_TX_CHANNEL_TAG_EN: precede each granted byte with a channel tag frame.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int         numRequesters     = 4,
  parameter int         waitTimeoutCycles = 2048,
  parameter logic [7:0] tagBase           = TAG_BASE_DEFAULT,
  localparam int        idWidth           = id_width(numRequesters)
) (
  input  logic                       systemClock,
  input  logic                       systemReset,
  input  logic [numRequesters-1:0]   requestValid,
  input  logic [numRequesters*8-1:0] requestByte,
  output logic [numRequesters-1:0]   requestReady,
  output logic [idWidth-1:0]         grantIndex,
  output logic                       schedulerBusy,
  output logic                       transmitDataValid,
  output logic [7:0]                 transmitByte,
  input  logic                       isTransmitActive,
  input  logic                       isTransmitDone,
  output logic                       timeoutError
);

  localparam int                  cntWidth = $clog2(waitTimeoutCycles) + 1;
  localparam logic [cntWidth-1:0] cntLast  = cntWidth'(waitTimeoutCycles - 1);

  sched_state_e             state_q, state_d;
  logic [numRequesters-1:0] ready_q, ready_d;
  logic [idWidth-1:0]       grant_q, grant_d;
  logic [idWidth-1:0]       ptr_q, ptr_d;
  logic                     busy_q, busy_d;
  logic                     load_q, load_d;
  logic                     timeout_q, timeout_d;
  logic [7:0]               byte_q, byte_d;
  logic [cntWidth-1:0]      cnt_q, cnt_d;
  logic                     done_prev_q;
`ifdef UART_TX_CHANNEL_TAG_EN
  tag_phase_e               phase_q, phase_d;
  logic [7:0]               data_q, data_d;
`endif

  logic                     arb_found;
  logic [idWidth-1:0]       arb_winner;
  logic [7:0]               req_bytes [numRequesters];
  logic                     tx_quiet;
  logic                     done_rise;

  genvar gi;
  generate
    for (gi = 0; gi < numRequesters; gi++) begin : g_unpack
      assign req_bytes[gi] = requestByte[8*gi +: 8];
    end
  endgenerate

  assign tx_quiet  = ~isTransmitActive & ~isTransmitDone;
  assign done_rise = isTransmitDone & ~done_prev_q;

  rr_arbiter #(
    .numRequesters(numRequesters),
    .idWidth      (idWidth)
  ) u_arb (
    .request_i(requestValid),
    .pointer_i(ptr_q),
    .found_o  (arb_found),
    .winner_o (arb_winner)
  );

  always_comb begin
    state_d   = state_q;
    ready_d   = '0;
    load_d    = 1'b0;
    timeout_d = 1'b0;
    byte_d    = byte_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
`ifdef UART_TX_CHANNEL_TAG_EN
    phase_d   = phase_q;
    data_d    = data_q;
`endif
    unique case (state_q)
      // The transmitter has no reset, so wait out any frame left in flight.
      SETTLE: if (tx_quiet) state_d = IDLE;
      IDLE: begin
        if (arb_found) begin
          ready_d = numRequesters'(1) << arb_winner;
          load_d  = 1'b1;
          grant_d = arb_winner;
          busy_d  = 1'b1;
          ptr_d   = (arb_winner == idWidth'(numRequesters - 1)) ? '0 : arb_winner + 1'b1;
          cnt_d   = '0;
          state_d = WAIT_DONE;
`ifdef UART_TX_CHANNEL_TAG_EN
          byte_d  = tagBase | 8'(arb_winner);
          data_d  = req_bytes[arb_winner];
          phase_d = PHASE_TAG;
`else
          byte_d  = req_bytes[arb_winner];
`endif
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (done_rise) begin
          state_d = DRAIN;
        end else if (cnt_q == cntLast) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = SETTLE;
        end
      end
      DRAIN: begin
        if (tx_quiet) begin
`ifdef UART_TX_CHANNEL_TAG_EN
          if (phase_q == PHASE_TAG) begin
            load_d  = 1'b1;
            byte_d  = data_q;
            phase_d = PHASE_DATA;
            cnt_d   = '0;
            state_d = WAIT_DONE;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge systemClock) begin
    if (systemReset) begin
      state_q     <= SETTLE;
      ready_q     <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      load_q      <= 1'b0;
      timeout_q   <= 1'b0;
      byte_q      <= 8'h00;
      cnt_q       <= '0;
      done_prev_q <= 1'b0;
`ifdef UART_TX_CHANNEL_TAG_EN
      phase_q     <= PHASE_TAG;
      data_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      load_q      <= load_d;
      timeout_q   <= timeout_d;
      byte_q      <= byte_d;
      cnt_q       <= cnt_d;
      done_prev_q <= isTransmitDone;
`ifdef UART_TX_CHANNEL_TAG_EN
      phase_q     <= phase_d;
      data_q      <= data_d;
`endif
    end
  end

  assign requestReady      = ready_q;
  assign grantIndex        = grant_q;
  assign schedulerBusy     = busy_q;
  assign transmitDataValid = load_q;
  assign transmitByte      = byte_q;
  assign timeoutError      = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: behavioural transmitter, queued requesters and a frame scoreboard.
module tb_uart_tx_scheduler;

  localparam int         N   = 4;
  localparam int         TO  = 16;
  localparam logic [7:0] TAG = 8'hA0;

  logic           clk = 1'b0;
  logic           srst;
  logic [N-1:0]   requestValid;
  logic [N*8-1:0] requestByte;
  logic [N-1:0]   requestReady;
  logic [1:0]     grantIndex;
  logic           schedulerBusy;
  logic           transmitDataValid;
  logic [7:0]     transmitByte;
  logic           tx_active = 1'b0;
  logic           tx_done   = 1'b0;
  logic           timeoutError;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .numRequesters    (N),
    .waitTimeoutCycles(TO)
  ) dut (
    .systemClock      (clk),
    .systemReset      (srst),
    .requestValid     (requestValid),
    .requestByte      (requestByte),
    .requestReady     (requestReady),
    .grantIndex       (grantIndex),
    .schedulerBusy    (schedulerBusy),
    .transmitDataValid(transmitDataValid),
    .transmitByte     (transmitByte),
    .isTransmitActive (tx_active),
    .isTransmitDone   (tx_done),
    .timeoutError     (timeoutError)
  );

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] idx;
    logic [3:0] rdy;
  } frame_t;

  frame_t exp_q[$];
  frame_t obs_q[$];
  int vectors = 0;
  int errors  = 0;
  int grants_exp = 0;

  // Transmitter model: active for frame_len cycles after a load, then done for done_hold cycles.
  int frame_len = 5;
  int done_hold = 1;
  bit hang      = 1'b0;
  int m_act     = 0;
  int m_done    = 0;

  always @(posedge clk) begin
    if (transmitDataValid) begin
      tx_active <= 1'b1;
      tx_done   <= 1'b0;
      m_act     <= frame_len;
      m_done    <= 0;
    end else if (m_act > 1) begin
      m_act <= m_act - 1;
    end else if (m_act == 1) begin
      if (!hang) begin
        m_act     <= 0;
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
        m_done    <= done_hold;
      end
    end else if (m_done > 1) begin
      m_done <= m_done - 1;
    end else if (m_done == 1) begin
      m_done  <= 0;
      tx_done <= 1'b0;
    end
  end

  // Monitor
  int cyc = 0;
  int load_cyc = 0, to_cyc = 0, timeouts = 0, overlaps = 0, ready_pulses = 0, nonhot = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (transmitDataValid) begin
      frame_t f;
      f.b   = transmitByte;
      f.idx = grantIndex;
      f.rdy = requestReady;
      obs_q.push_back(f);
      load_cyc = cyc;
      if (tx_active || tx_done) overlaps++;
    end
    if (timeoutError) begin
      timeouts++;
      to_cyc = cyc;
    end
    if (|requestReady) begin
      ready_pulses++;
      if ($countones(requestReady) != 1) nonhot++;
    end
  end

  // Requesters: each holds its head byte until its ready pulse is seen.
  logic [7:0] src_mem [N][16];
  int src_head [N] = '{default: 0};
  int src_tail [N] = '{default: 0};

  initial begin
    requestValid = '0;
    requestByte  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (requestReady[i] && src_head[i] != src_tail[i]) src_head[i] = src_head[i] + 1;
      end
      for (int i = 0; i < N; i++) begin
        requestValid[i]       = (src_head[i] != src_tail[i]);
        requestByte[8*i +: 8] = (src_head[i] != src_tail[i]) ? src_mem[i][src_head[i] % 16] : 8'h00;
      end
    end
  end

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (src_head[i] != src_tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input int idx, input logic [7:0] data);
    src_mem[idx][src_tail[idx] % 16] = data;
    src_tail[idx] = src_tail[idx] + 1;
  endtask

  // Frames expected for one grant; aborted grants never reach the data frame in tag mode.
  task automatic expect_grant(input int idx, input logic [7:0] data, input bit aborted);
    frame_t f;
    grants_exp++;
    f.idx = 2'(idx);
    f.rdy = 4'(1 << idx);
`ifdef UART_TX_CHANNEL_TAG_EN
    f.b = TAG | 8'(idx);
    exp_q.push_back(f);
    if (!aborted) begin
      f.b   = data;
      f.rdy = '0;
      exp_q.push_back(f);
    end
`else
    f.b = data;
    if (aborted || !aborted) exp_q.push_back(f);
`endif
  endtask

  task automatic wait_sb(input string tag);
    int n;
    frame_t e, o;
    n = 0;
    while ((obs_q.size() < exp_q.size() || schedulerBusy || tx_active || tx_done || pending())
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finish"}, 32'(n < 3000), 32'd1);
    repeat (4) @(negedge clk);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_byte"}, 32'(o.b), 32'(e.b));
      check({tag, "_idx"},  32'(o.idx), 32'(e.idx));
      check({tag, "_rdy"},  32'(o.rdy), 32'(e.rdy));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 srst = 1'b1;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
  endtask

  initial begin
    int n;
    int rp0;
    srst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",   32'(requestReady), 32'd0);
    check("rst_grant",   32'(grantIndex), 32'd0);
    check("rst_busy",    32'(schedulerBusy), 32'd0);
    check("rst_valid",   32'(transmitDataValid), 32'd0);
    check("rst_byte",    32'(transmitByte), 32'd0);
    check("rst_timeout", 32'(timeoutError), 32'd0);

    // Single request: grant visible one cycle after the sampling edge.
    @(posedge clk);
    #1 srst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_req(2, 8'h3C);
    expect_grant(2, 8'h3C, 1'b0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("lat_ready", 32'(requestReady), 32'b0100);
    check("lat_valid", 32'(transmitDataValid), 32'd1);
`ifdef UART_TX_CHANNEL_TAG_EN
    check("lat_byte",  32'(transmitByte), 32'hA2);
`else
    check("lat_byte",  32'(transmitByte), 32'h3C);
`endif
    check("lat_grant", 32'(grantIndex), 32'd2);
    check("lat_busy",  32'(schedulerBusy), 32'd1);
    @(negedge clk);
    check("lat_ready_clr", 32'(requestReady), 32'd0);
    check("lat_valid_clr", 32'(transmitDataValid), 32'd0);
    wait_sb("single");

    // All four requesting, done held two cycles: order 0,1,2,3,0.
    do_reset();
    done_hold = 2;
    push_req(0, 8'h10);
    push_req(1, 8'h11);
    push_req(2, 8'h12);
    push_req(3, 8'h13);
    push_req(0, 8'h14);
    expect_grant(0, 8'h10, 1'b0);
    expect_grant(1, 8'h11, 1'b0);
    expect_grant(2, 8'h12, 1'b0);
    expect_grant(3, 8'h13, 1'b0);
    expect_grant(0, 8'h14, 1'b0);
    wait_sb("rr");

    // Done never arrives: timeout 16 cycles after the load, then recovery.
    do_reset();
    done_hold = 1;
    hang = 1'b1;
    push_req(1, 8'h77);
    expect_grant(1, 8'h77, 1'b1);
    n = 0;
    while (timeouts == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("to_seen", 32'(timeouts), 32'd1);
    check("to_delay", 32'(to_cyc - load_cyc), 32'(TO));
    check("to_busy", 32'(schedulerBusy), 32'd0);
    @(posedge clk);
    #1 push_req(2, 8'h88);
    expect_grant(2, 8'h88, 1'b0);
    repeat (20) @(negedge clk);
    check("to_hold", 32'(obs_q.size()), 32'd1);
    hang = 1'b0;
    wait_sb("timeout");
    check("to_total", 32'(timeouts), 32'd1);

    // Reset while the transmitter is mid-frame.
    frame_len = 8;
    @(posedge clk);
    #1 push_req(3, 8'h5A);
    expect_grant(3, 8'h5A, 1'b1);
    n = 0;
    while (obs_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1 srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy",  32'(schedulerBusy), 32'd0);
    check("mid_rst_grant", 32'(grantIndex), 32'd0);
    check("mid_rst_valid", 32'(transmitDataValid), 32'd0);
    check("mid_rst_model", 32'(tx_active), 32'd1);
    srst = 1'b0;
    push_req(0, 8'h66);
    expect_grant(0, 8'h66, 1'b0);
    wait_sb("midreset");

    // One requester, one ready pulse per grant.
    frame_len = 5;
    do_reset();
    rp0 = ready_pulses;
    push_req(1, 8'h55);
    expect_grant(1, 8'h55, 1'b0);
    wait_sb("tag");
    check("tag_ready_once", 32'(ready_pulses - rp0), 32'd1);

    check("no_overlap", 32'(overlaps), 32'd0);
    check("onehot_ready", 32'(nonhot), 32'd0);
    check("ready_total", 32'(ready_pulses), 32'(grants_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one UART byte transmitter between numRequesters independent byte sources. Each requester offers one byte over a valid/ready handshake. The scheduler grants one requester, issues a single-cycle load pulse to the transmitter, and waits for the frame to complete before granting the next requester. It sits between the debug/telemetry producers and the single serial TX pin.

Parameters:
numRequesters, 4, number of requester ports (2..8); index width idWidth = $clog2(numRequesters), minimum 1
waitTimeoutCycles, 2048, maximum cycles from load pulse to transmitter done before the scheduler aborts the wait
tagBase, 8'hA0, upper bits of the channel tag byte (used only with the optional feature)

Ports:
systemClock  in  1  clock
systemReset  in  1  synchronous reset, active-high
requestValid  in  numRequesters  per-requester byte offered
requestByte  in  numRequesters*8  byte for requester i in bits [8i+7:8i]
requestReady  out  numRequesters  one-cycle accept pulse, one-hot
grantIndex  out  idWidth  index of the last granted requester
schedulerBusy  out  1  high from grant until return to IDLE
transmitDataValid  out  1  one-cycle load pulse to the transmitter
transmitByte  out  8  byte to the transmitter, held stable until the next load
isTransmitActive  in  1  transmitter busy flag
isTransmitDone  in  1  transmitter completion flag; may stay high for more than one cycle
timeoutError  out  1  one-cycle pulse when a wait times out

Behaviour:
- All outputs are registered. Reset values: requestReady=0, grantIndex=0, schedulerBusy=0, transmitDataValid=0, transmitByte=8'h00, timeoutError=0. The priority pointer resets to 0 and the state resets to SETTLE.
- SETTLE: the transmitter has no reset and may be mid-frame. Wait until isTransmitActive==0 and isTransmitDone==0, then go to IDLE. Requests are ignored in this state.
- IDLE: requestValid is sampled at each edge. If any bit is set, the winner is the first set index searching upward from the pointer, wrapping modulo numRequesters. At that edge:
  - requestReady[w]<=1
  - transmitByte<=requestByte[w]
  - transmitDataValid<=1
  - grantIndex<=w
  - schedulerBusy<=1
  - pointer<=(w+1) mod numRequesters
  - timeout counter cleared
  - go to WAIT_DONE
- Grant latency: requestReady and transmitDataValid are high together for exactly the one cycle after the sampling edge.
- WAIT_DONE: clear requestReady and transmitDataValid. Track the previous isTransmitDone. On a rising edge of isTransmitDone, go to DRAIN. If the counter reaches waitTimeoutCycles-1, pulse timeoutError, clear schedulerBusy, and go to SETTLE.
- DRAIN: wait for isTransmitDone==0 and isTransmitActive==0, then clear schedulerBusy and go to IDLE. The earliest next grant is sampled on the edge after DRAIN exits.
- Requesters hold requestValid and requestByte stable until requestReady. A valid that drops before grant is simply not granted. Requests arriving while busy wait; none are lost or reordered per requester.
- Reset mid-frame: all outputs return to reset values next cycle. The accepted byte is abandoned (its ready pulse has already fired) and the scheduler re-enters SETTLE.
- With a single requester asserting continuously, that requester is granted back-to-back, with no starvation checks needed.

Optional Feature:
UART_TX_CHANNEL_TAG_EN
- Defined: each granted byte is sent as two frames. First frame is the tag byte (tagBase | w), where w occupies the low idWidth bits. Second frame is the data byte. A phase register selects tag or data. After DRAIN in the tag phase, the scheduler issues the data byte directly (transmitDataValid pulse, WAIT_DONE) without re-arbitration. requestReady pulses only once, at the tag issue. A timeout in either phase aborts both frames.
- Not defined: one frame per grant, no phase register, tagBase unused.

Decomposition:
- Package uart_ctrl_pkg: state enum (SETTLE, IDLE, WAIT_DONE, DRAIN), tag-phase enum, default tagBase constant, idWidth helper function.
- Sub-module rr_arbiter: parameterised round-robin pick. Takes the request vector and pointer; returns a found flag and the winner index. Combinational, reused by other shared-resource schedulers.

Test Plan:
- Reset, transmitter idle, requestValid=4'b0100 with byte 8'h3C -> one cycle later requestReady=4'b0100, transmitDataValid=1, transmitByte=8'h3C, grantIndex=2.
- All four requesting continuously, bytes 8'h10..8'h13 -> grant order 0,1,2,3,0, each load only after done falls and active falls.
- Model holds isTransmitDone high for 2 cycles -> exactly one grant per frame, no double issue.
- isTransmitDone never asserts, waitTimeoutCycles=16 -> timeoutError pulses 16 cycles after the load, state returns to SETTLE, next grant proceeds.
- systemReset asserted mid-frame while the model is still active -> no transmitDataValid until isTransmitActive falls.
- UART_TX_CHANNEL_TAG_EN defined, requester 1 sends 8'h55 -> frames 8'hA1 then 8'h55, one requestReady pulse.
